// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch-side initiator for a byte-addressed, zero-latency instruction memory.
//   Owns the PC, presents the word-aligned read address, and captures the
//   returned word together with its PC into a small prefetch FIFO. Decode
//   consumes the FIFO head through a valid/ready handshake. A redirect (taken
//   branch/jump) flushes the FIFO and restarts fetch at the aligned target.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   DEPTH      prefetch FIFO entries (power of 2, >= 2)
//   MEM_BYTES  instruction memory size in bytes (power of 2)
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   instructionAddress  word-aligned read address, wrapped to MEM_BYTES
//   instruction         word returned combinationally for instructionAddress
//   redirect            taken branch/jump this cycle
//   redirectTarget      new PC when redirect=1 (low two bits ignored)
//   insReady            decode accepts the head entry
//   insValid            head entry valid
//   insOut              head instruction word (0 when empty)
//   insPc               PC of the head instruction (0 when empty)
//   insPcPlus4          insPc + 4 (4 when empty)
//   fetchCount          words pushed into the FIFO, saturating
//   flushCount          valid entries discarded by redirects, saturating
//
// Optional feature
//   FETCH_PERF_EN  when defined, adds fetchCount/flushCount and their counters.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          DEPTH     = 4,
   parameter int          MEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] instructionAddress,
   input  logic [31:0] instruction,
   input  logic        redirect,
   input  logic [31:0] redirectTarget,
   input  logic        insReady,
   output logic        insValid,
   output logic [31:0] insOut,
   output logic [31:0] insPc,
   output logic [31:0] insPcPlus4
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetchCount,
   output logic [15:0] flushCount
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   pcReg;
   logic [PW-1:0] rdPtrReg;
   logic [PW-1:0] wrPtrReg;
   logic [CW-1:0] countReg;

   // FIFO storage; read combinationally so the head is visible the cycle
   // after it is written.
   logic [31:0] pcMem  [DEPTH];
   logic [31:0] insMem [DEPTH];

   logic push;
   logic pop;

   assign instructionAddress = {pcReg[31:2], 2'b00} & 32'(MEM_BYTES - 1);

   assign insValid = (countReg != '0);
   assign pop      = insValid && insReady;
   // A full FIFO can still accept a word when the head leaves in the same cycle.
   assign push     = !redirect && ((countReg < CW'(DEPTH)) || pop);

   assign insOut     = insValid ? insMem[rdPtrReg]        : 32'h0;
   assign insPc      = insValid ? pcMem[rdPtrReg]         : 32'h0;
   assign insPcPlus4 = insValid ? pcMem[rdPtrReg] + 32'd4 : 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcReg    <= RESET_PC;
         rdPtrReg <= '0;
         wrPtrReg <= '0;
         countReg <= '0;
      end else if (redirect) begin
         // Any head handshake this cycle has already been taken by decode;
         // everything else is discarded.
         pcReg    <= {redirectTarget[31:2], 2'b00};
         rdPtrReg <= '0;
         wrPtrReg <= '0;
         countReg <= '0;
      end else begin
         if (push) begin
            pcReg    <= pcReg + 32'd4;
            wrPtrReg <= wrPtrReg + PW'(1);
         end
         if (pop) begin
            rdPtrReg <= rdPtrReg + PW'(1);
         end
         countReg <= countReg + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pcMem[wrPtrReg]  <= pcReg;
         insMem[wrPtrReg] <= instruction;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetchCountReg;
   logic [15:0] flushCountReg;
   logic [CW-1:0] flushDelta;
   logic [16:0]   flushSum;

   // Entries lost to a redirect exclude the head that decode accepts that cycle.
   assign flushDelta = countReg - CW'(pop);
   assign flushSum   = {1'b0, flushCountReg} + 17'(flushDelta);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetchCountReg <= '0;
         flushCountReg <= '0;
      end else begin
         if (push && (fetchCountReg != 32'hFFFF_FFFF)) begin
            fetchCountReg <= fetchCountReg + 32'd1;
         end
         if (redirect) begin
            flushCountReg <= flushSum[16] ? 16'hFFFF : flushSum[15:0];
         end
      end
   end

   assign fetchCount = fetchCountReg;
   assign flushCount = flushCountReg;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed scoreboard bench. Stimulus pushes the {pc, word} pairs decode is
//   expected to receive into a queue; a monitor pops and compares on every
//   head handshake. Immediate state checks (address, valid, counters) are made
//   by the stimulus process one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] instructionAddress;
   logic [31:0] instruction;
   logic        redirect;
   logic [31:0] redirectTarget;
   logic        insReady;
   logic        insValid;
   logic [31:0] insOut;
   logic [31:0] insPc;
   logic [31:0] insPcPlus4;
`ifdef FETCH_PERF_EN
   logic [31:0] fetchCount;
   logic [15:0] flushCount;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } entry_t;

   entry_t expQ[$];
   int     total = 0;
   int     bad   = 0;

   instruction_fetch_unit #(
      .RESET_PC (32'h0),
      .DEPTH    (4),
      .MEM_BYTES(4096)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .instructionAddress(instructionAddress),
      .instruction       (instruction),
      .redirect          (redirect),
      .redirectTarget    (redirectTarget),
      .insReady          (insReady),
      .insValid          (insValid),
      .insOut            (insOut),
      .insPc             (insPc),
      .insPcPlus4        (insPcPlus4)
`ifdef FETCH_PERF_EN
      ,
      .fetchCount        (fetchCount),
      .flushCount        (flushCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a tag in the top byte plus the word's byte address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'h1300_0000 | a;
   endfunction

   always_comb instruction = memWord(instructionAddress);

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic expectPop(input logic [31:0] pc);
      entry_t e;
      e.pc  = pc;
      e.ins = memWord(pc & 32'h0000_0FFF);
      expQ.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset is asserted and released between clock edges to exercise the
   // asynchronous assertion path.
   task automatic doReset(input logic rdy);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_valid", {31'h0, insValid}, 32'h0);
      check("rst_insOut", insOut, 32'h0);
      check("rst_insPc", insPc, 32'h0);
      check("rst_pcPlus4", insPcPlus4, 32'd4);
      check("rst_addr", instructionAddress, 32'h0);
`ifdef FETCH_PERF_EN
      check("rst_fetchCount", fetchCount, 32'h0);
      check("rst_flushCount", {16'h0, flushCount}, 32'h0);
`endif
      redirect       = 1'b0;
      redirectTarget = 32'h0;
      insReady       = rdy;
      @(posedge clk);
      #4;
      rst_n = 1'b1;
   endtask

   // Monitor: every handshake seen before an edge consumes one expected entry.
   always @(negedge clk) begin
      if (rst_n && insValid && insReady) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got pc %h expected no pop", insPc);
         end else begin
            entry_t e;
            e = expQ.pop_front();
            $display("pop pc=%h ins=%h (expected pc=%h ins=%h)", insPc, insOut, e.pc, e.ins);
            check("pop_pc", insPc, e.pc);
            check("pop_ins", insOut, e.ins);
            check("pop_pcPlus4", insPcPlus4, e.pc + 32'd4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      redirect       = 1'b0;
      redirectTarget = 32'h0;
      insReady       = 1'b0;
      #2;
      check("init_valid", {31'h0, insValid}, 32'h0);
      check("init_pcPlus4", insPcPlus4, 32'd4);

      // Streaming with decode always ready.
      doReset(1'b1);
      check("a_addr0", instructionAddress, 32'h0);
      for (int i = 0; i < 5; i++) expectPop(32'(i * 4));
      for (int n = 1; n <= 6; n++) begin
         tick();
         check("a_addr", instructionAddress, 32'(n * 4));
         check("a_insPc", insPc, 32'((n - 1) * 4));
      end
      insReady = 1'b0;

      // Fill with decode stalled, then drain in order.
      doReset(1'b0);
      for (int n = 1; n <= 4; n++) tick();
      for (int n = 0; n < 3; n++) begin
         check("b_hold_addr", instructionAddress, 32'h10);
         check("b_hold_valid", {31'h0, insValid}, 32'h1);
         check("b_hold_pc", insPc, 32'h0);
         if (n < 2) tick();
      end
      for (int i = 0; i < 6; i++) expectPop(32'(i * 4));
      insReady = 1'b1;
      tick();
      check("b_refill_addr", instructionAddress, 32'h14);
      check("b_refill_pc", insPc, 32'h4);
      for (int n = 0; n < 5; n++) tick();
      insReady = 1'b0;

      // Redirect on a full FIFO while decode takes the head.
      doReset(1'b0);
      for (int n = 1; n <= 4; n++) tick();
      expectPop(32'h0);
      redirect       = 1'b1;
      redirectTarget = 32'h20;
      insReady       = 1'b1;
      tick();
      redirect = 1'b0;
      check("c_valid_after", {31'h0, insValid}, 32'h0);
      check("c_addr", instructionAddress, 32'h20);
`ifdef FETCH_PERF_EN
      check("c_fetchCount", fetchCount, 32'd4);
      check("c_flushCount", {16'h0, flushCount}, 32'd3);
`endif
      expectPop(32'h20);
      tick();
      check("c_target_valid", {31'h0, insValid}, 32'h1);
      check("c_target_pc", insPc, 32'h20);
      check("c_target_ins", insOut, memWord(32'h20));
      tick();
      insReady = 1'b0;

      // Unaligned target, back-to-back redirect, and address wrap.
      redirect       = 1'b1;
      redirectTarget = 32'h37;
      tick();
      check("d_align_addr", instructionAddress, 32'h34);
      check("d_align_valid", {31'h0, insValid}, 32'h0);
`ifdef FETCH_PERF_EN
      check("d_flushCount", {16'h0, flushCount}, 32'd4);
`endif
      redirectTarget = 32'hFFC;
      tick();
      check("d_b2b_addr", instructionAddress, 32'hFFC);
      redirect = 1'b0;
      insReady = 1'b1;
      expectPop(32'hFFC);
      expectPop(32'h1000);
      tick();
      check("d_wrap_addr", instructionAddress, 32'h0);
      check("d_wrap_headpc", insPc, 32'hFFC);
      tick();
      check("d_wrap_pc", insPc, 32'h1000);
      check("d_wrap_ins", insOut, memWord(32'h0));
      check("d_wrap_pcPlus4", insPcPlus4, 32'h1004);
      tick();
      insReady = 1'b0;

      // Asynchronous reset with three entries queued, then resume.
      doReset(1'b0);
      for (int n = 1; n <= 3; n++) tick();
      check("e_queued_valid", {31'h0, insValid}, 32'h1);
      check("e_queued_addr", instructionAddress, 32'hC);
      expectPop(32'h0);
      expectPop(32'h4);
      doReset(1'b1);
      tick();
      check("e_resume_pc", insPc, 32'h0);
      check("e_resume_addr", instructionAddress, 32'h4);
      tick();
      tick();
      insReady = 1'b0;

      // Ten pushes, then a redirect that discards two entries.
      doReset(1'b0);
      tick();
      tick();
      for (int i = 0; i < 8; i++) expectPop(32'(i * 4));
      insReady = 1'b1;
      for (int n = 0; n < 8; n++) tick();
      insReady       = 1'b0;
      redirect       = 1'b1;
      redirectTarget = 32'h100;
      tick();
      redirect = 1'b0;
      check("f_valid_after", {31'h0, insValid}, 32'h0);
      check("f_addr", instructionAddress, 32'h100);
`ifdef FETCH_PERF_EN
      check("f_fetchCount", fetchCount, 32'd10);
      check("f_flushCount", {16'h0, flushCount}, 32'd2);
`endif
      tick();
      check("f_target_valid", {31'h0, insValid}, 32'h1);
      check("f_target_pc", insPc, 32'h100);

      tick();
      check("queue_drained", 32'(expQ.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
